data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting between the pipelined CPU's memory stage and the backing data memory. It responds to CPU load/store requests, answering read hits in the same cycle. It stalls the pipeline while a read miss is filled or a store is written through over a request/acknowledge handshake to main memory.

## Interface
Parameters:
- DATA_WIDTH, 32, word width of the CPU and memory data buses
- ADDRESS_WIDTH, 32, byte-address width
- SETS, 16, number of one-word lines; power of two, at least 2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  CPU memory-stage access valid
- we  in  1  CPU store (1) or load (0)
- a  in  ADDRESS_WIDTH  CPU byte address; a[1:0] ignored (word accesses only)
- wd  in  DATA_WIDTH  CPU store data
- rd  out  DATA_WIDTH  load data to the CPU
- stall  out  1  freeze the pipeline; CPU holds req/we/a/wd stable while high
- mem_req  out  1  backing-memory request, held until acknowledged
- mem_we  out  1  backing-memory write
- mem_a  out  ADDRESS_WIDTH  backing-memory address, word-aligned (low 2 bits 0)
- mem_wd  out  DATA_WIDTH  backing-memory write data
- mem_rd  in  DATA_WIDTH  backing-memory read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse from backing memory

## Operation
- Address split: index = a[2+log2(SETS)-1:2]; tag = a[ADDRESS_WIDTH-1:2+log2(SETS)].
- Each line stores a valid bit, tag and data word. Reset clears all valid bits.
- FSM states are IDLE, FILL, WRITE and DONE. Reset state is IDLE.
- IDLE, no req: stall=0, rd=0.
- IDLE, load hit (valid and tag equal): rd = line data combinationally, stall=0, state stays IDLE.
- IDLE, load miss: stall=1 combinationally, next state FILL.
- IDLE, store (hit or miss): stall=1, next state WRITE. On a hit, the line data is updated to wd when mem_ack arrives. A miss does not allocate.
- FILL: mem_req=1, mem_we=0, mem_a={a[ADDRESS_WIDTH-1:2],2'b00}, stall=1. On mem_ack, write mem_rd into the line, set valid, load tag, and go to DONE.
- WRITE: mem_req=1, mem_we=1, mem_wd=wd, stall=1. On mem_ack, go to DONE.
- DONE: stall=0 for exactly one cycle, and rd = line data for a load (0 for a store). Next state is IDLE. DONE prevents a held request from being re-issued.
- mem_ack is ignored whenever mem_req=0.
- Reset outputs: stall=0, rd=0, mem_req=0, mem_we=0, mem_a=0, mem_wd=0.

## Timing
- Read hit: zero added latency; data is valid in the request cycle.
- Read miss: the request arrives in cycle 0, and mem_req rises in cycle 1. With mem_ack in cycle k (k≥1), DONE occurs in cycle k+1 with stall=0. The minimum total stall is 2 cycles.
- Store: same cycle count as a read miss, whether it hits or misses.
- mem_req, mem_we, mem_a and mem_wd are registered and stable from request until ack.
- Reset asserted mid-transaction: the state goes to IDLE, mem_req drops immediately (asynchronous), valid bits clear, and any ack in flight is dropped.
- A store to a line whose fill is pending cannot occur, because the pipeline is frozen.
- Index aliasing: a fill overwrites the previous line regardless of its tag.

## Configuration
- DATA_CACHE_STATS_EN: when defined, the block adds outputs hit_count and miss_count, each 32 bits.
  - Both are cleared by reset.
  - A load hit in IDLE increments hit_count once. A load miss entering FILL increments miss_count once. Stores are not counted.
  - Both counters saturate at 0xFFFFFFFF.
- When the macro is undefined, these ports and counters do not exist and the remaining behaviour is identical.

## Test plan
- Reset then load of 0x100 with mem_ack in the second FILL cycle returning 0xDEADBEEF: stall is high for 3 cycles and rd=0xDEADBEEF in DONE. A repeat load of 0x100 hits with stall=0 and returns 0xDEADBEEF.
- Store 0x12345678 to 0x100 after the fill: mem_we=1, mem_a=0x100, mem_wd=0x12345678. After the ack, a load of 0x100 hits and returns 0x12345678.
- Store 0xCAFEF00D to miss address 0x200: the write goes through to memory and the line is not allocated, so a following load of 0x200 misses and raises mem_req.
- Aliasing with SETS=16: fill 0x100, then load 0x140 (same index, different tag). The second load misses and evicts the first, and reloading 0x100 misses again.
- Assert rst low in the middle of FILL: mem_req drops the same cycle, a late mem_ack is ignored, and a subsequent load of 0x100 misses.
- With DATA_CACHE_STATS_EN, run 1 miss followed by 3 hits: hit_count=3 and miss_count=1.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are compiled in when DATA_CACHE_STATS_EN is defined.
module data_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0]    wd,
    output logic [DATA_WIDTH-1:0]    rd,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    input  logic                     mem_ack
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int IW = $clog2(SETS);
    localparam int TW = ADDRESS_WIDTH - 2 - IW;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [SETS-1:0]            valid_q;
    logic [TW-1:0]              tag_q  [SETS];
    logic [DATA_WIDTH-1:0]      data_q [SETS];
    logic                       mem_req_q, mem_we_q;
    logic [ADDRESS_WIDTH-1:0]   mem_a_q;
    logic [DATA_WIDTH-1:0]      mem_wd_q;

    logic [IW-1:0]              idx;
    logic [TW-1:0]              tag;
    logic                       hit, ack, issue;
    logic                       addr_unused;

    assign idx         = a[IW+1:2];
    assign tag         = a[ADDRESS_WIDTH-1:IW+2];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign ack         = mem_ack && mem_req_q;
    assign addr_unused = ^a[1:0];

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        rd      = '0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        stall   = 1'b1;
                        issue   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        rd = data_q[idx];
                    end else begin
                        stall   = 1'b1;
                        issue   = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL, WRITE: begin
                stall = 1'b1;
                if (ack) state_d = DONE;
            end
            DONE: begin
                if (req && !we) rd = data_q[idx];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FILL && ack) valid_q[idx] <= 1'b1;
            // Bus outputs are captured at issue so they stay stable until the ack.
            if (issue) begin
                mem_req_q <= 1'b1;
                mem_we_q  <= we;
                mem_a_q   <= {a[ADDRESS_WIDTH-1:2], 2'b00};
                if (we) mem_wd_q <= wd;
            end else if (ack) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
        end
    end

    // Store hits refresh the line only once memory has accepted the write.
    always_ff @(posedge clk) begin
        if (state_q == FILL && ack) begin
            data_q[idx] <= mem_rd;
            tag_q[idx]  <= tag;
        end else if (state_q == WRITE && ack && hit) begin
            data_q[idx] <= wd;
        end
    end

    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_wd  = mem_wd_q;

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == IDLE && req && !we) begin
            if (hit) begin
                if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
